// File: rtl/quicksort_ctrl_pkg.sv
// Shared definitions for the quicksort sequencer: FSM encoding, element width
// and the range-stack entry width helper.
package quicksort_ctrl_pkg;

    localparam int ELEM_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POP     = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_PUSH    = 3'd5,
        ST_FINISH  = 3'd6
    } qs_state_e;

    // A stack entry is a {lo, hi} index pair.
    function automatic int stack_entry_w(input int idx_w);
        return 2 * idx_w;
    endfunction

endpackage

// File: rtl/quicksort_ctrl_if.sv
// Handshake bundle between the quicksort sequencer (master) and the
// partition stage (slave).
interface quicksort_ctrl_if
    import quicksort_ctrl_pkg::*;
#(
    parameter int ARR_WIDTH = 4,
    parameter int IDX_W     = 4
);
    logic [ARR_WIDTH*ELEM_W-1:0] part_array_out;
    logic [IDX_W-1:0]            part_lo;
    logic [IDX_W-1:0]            part_hi;
    logic                        part_start;
    logic [ARR_WIDTH*ELEM_W-1:0] part_array_in;
    logic [IDX_W-1:0]            part_pivot;
    logic                        part_ready;

    modport master (
        output part_array_out, part_lo, part_hi, part_start,
        input  part_array_in, part_pivot, part_ready
    );

    modport slave (
        input  part_array_out, part_lo, part_hi, part_start,
        output part_array_in, part_pivot, part_ready
    );
endinterface

// File: rtl/quicksort_ctrl_range_stack.sv
// LIFO of pending {lo,hi} ranges; pop data is the current top, valid in the
// same cycle as pop. Pushes into a full stack are dropped.
module range_stack
    import quicksort_ctrl_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            push,
    input  logic [stack_entry_w(IDX_W)-1:0] push_data,
    input  logic                            pop,
    output logic [stack_entry_w(IDX_W)-1:0] pop_data,
    output logic                            empty,
    output logic                            full
);
    localparam int ENTRY_W = stack_entry_w(IDX_W);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   top_idx_s;
    logic [PTR_W-1:0]   wr_idx_s;

    assign empty     = (count_r == CNT_W'(0));
    assign full      = (count_r == CNT_W'(DEPTH));
    assign top_idx_s = PTR_W'(count_r - CNT_W'(1));
    assign wr_idx_s  = PTR_W'(count_r);
    assign pop_data  = empty ? {ENTRY_W{1'b0}} : mem_r[top_idx_s];

    // Storage and occupancy count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= CNT_W'(0);
            mem_r   <= '{default: {ENTRY_W{1'b0}}};
        end else if (clear) begin
            count_r <= CNT_W'(0);
        end else if (push && !full) begin
            mem_r[wr_idx_s] <= push_data;
            count_r         <= count_r + CNT_W'(1);
        end else if (pop && !empty) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/quicksort_ctrl.sv
// Quicksort sequencer: walks a stack of pending ranges, launches the partition
// stage on each and pushes the resulting sub-ranges until the array is sorted.
module quicksort_ctrl
    import quicksort_ctrl_pkg::*;
#(
    parameter int ARR_WIDTH   = 4,
    parameter int IDX_W       = 4,
    parameter int STACK_DEPTH = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ARR_WIDTH*ELEM_W-1:0] array_in,
    input  logic                        start,
    quicksort_ctrl_if.master            part_bus,
    output logic [ARR_WIDTH*ELEM_W-1:0] sorted_out,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);
    localparam int DATA_W  = ARR_WIDTH * ELEM_W;
    localparam int ENTRY_W = stack_entry_w(IDX_W);
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARR_WIDTH - 1);
    localparam logic             MULTI    = (ARR_WIDTH > 1);

    qs_state_e          state_r, state_nxt_s;
    logic [DATA_W-1:0]  work_r, sorted_r;
    logic [IDX_W-1:0]   lo_r, hi_r, pivot_r;
    logic               right_pend_r, left_pend_r;
    logic [CNT_W-1:0]   tmo_cnt_r;
    logic               part_start_r, busy_r, done_r, error_r;

    logic               push_s, pop_s, clear_s, set_err_s;
    logic [ENTRY_W-1:0] push_data_s, pop_data_s;
    logic               empty_s, full_s;
    logic [IDX_W:0]     cap_pivot_s, lo_ext_s, hi_ext_s;
    logic               pivot_bad_s, need_right_s, need_left_s, tmo_hit_s;
    logic [IDX_W-1:0]   right_lo_s, left_hi_s;

    // Sub-range decisions use one extra bit so p-1 / p+1 never wrap.
    assign cap_pivot_s  = {1'b0, part_bus.part_pivot};
    assign lo_ext_s     = {1'b0, lo_r};
    assign hi_ext_s     = {1'b0, hi_r};
    assign pivot_bad_s  = (cap_pivot_s < lo_ext_s) || (cap_pivot_s > hi_ext_s);
    assign need_right_s = (cap_pivot_s + (IDX_W+1)'(1)) < hi_ext_s;
    assign need_left_s  = cap_pivot_s > (lo_ext_s + (IDX_W+1)'(1));
    assign tmo_hit_s    = (tmo_cnt_r == CNT_W'(TIMEOUT - 1));
    assign right_lo_s   = pivot_r + IDX_W'(1);
    assign left_hi_s    = pivot_r - IDX_W'(1);

    range_stack #(.IDX_W(IDX_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear_s),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (pop_data_s),
        .empty     (empty_s),
        .full      (full_s)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:    if (start) state_nxt_s = MULTI ? ST_POP : ST_FINISH;
                        else       state_nxt_s = ST_IDLE;
            ST_POP:     state_nxt_s = empty_s ? ST_FINISH : ST_ISSUE;
            ST_ISSUE:   state_nxt_s = ST_WAIT;
            ST_WAIT:    if (part_bus.part_ready) state_nxt_s = ST_CAPTURE;
                        else if (tmo_hit_s)      state_nxt_s = ST_FINISH;
                        else                     state_nxt_s = ST_WAIT;
            ST_CAPTURE: if (pivot_bad_s)                      state_nxt_s = ST_FINISH;
                        else if (need_right_s || need_left_s) state_nxt_s = ST_PUSH;
                        else                                  state_nxt_s = ST_POP;
            ST_PUSH:    if (full_s)                            state_nxt_s = ST_FINISH;
                        else if (right_pend_r && left_pend_r)  state_nxt_s = ST_PUSH;
                        else                                   state_nxt_s = ST_POP;
            ST_FINISH:  state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Stack control and error detection; right range is pushed before left.
    always_comb begin
        push_s      = 1'b0;
        pop_s       = 1'b0;
        clear_s     = 1'b0;
        set_err_s   = 1'b0;
        push_data_s = {ENTRY_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                push_s      = start & MULTI;
                push_data_s = {{IDX_W{1'b0}}, LAST_IDX};
            end
            ST_POP:     pop_s = ~empty_s;
            ST_WAIT:    set_err_s = ~part_bus.part_ready & tmo_hit_s;
            ST_CAPTURE: set_err_s = pivot_bad_s;
            ST_PUSH: begin
                push_s    = 1'b1;
                set_err_s = full_s;
                if (right_pend_r) push_data_s = {right_lo_s, hi_r};
                else              push_data_s = {lo_r, left_hi_s};
            end
            ST_FINISH:  clear_s = 1'b1;
            default:    clear_s = 1'b0;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work_r       <= {DATA_W{1'b0}};
            sorted_r     <= {DATA_W{1'b0}};
            lo_r         <= {IDX_W{1'b0}};
            hi_r         <= {IDX_W{1'b0}};
            pivot_r      <= {IDX_W{1'b0}};
            right_pend_r <= 1'b0;
            left_pend_r  <= 1'b0;
            tmo_cnt_r    <= CNT_W'(0);
            part_start_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            part_start_r <= (state_nxt_s == ST_ISSUE);
            done_r       <= (state_r == ST_FINISH) && !error_r;
            if (set_err_s) error_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        work_r  <= array_in;
                        error_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_POP: begin
                    if (!empty_s) begin
                        lo_r <= pop_data_s[ENTRY_W-1 -: IDX_W];
                        hi_r <= pop_data_s[IDX_W-1:0];
                    end
                end
                ST_ISSUE:   tmo_cnt_r <= CNT_W'(0);
                ST_WAIT:    tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                ST_CAPTURE: begin
                    work_r       <= part_bus.part_array_in;
                    pivot_r      <= part_bus.part_pivot;
                    right_pend_r <= need_right_s;
                    left_pend_r  <= need_left_s;
                end
                ST_PUSH: begin
                    if (right_pend_r) right_pend_r <= 1'b0;
                    else              left_pend_r  <= 1'b0;
                end
                ST_FINISH: begin
                    sorted_r <= work_r;
                    busy_r   <= 1'b0;
                end
                default: busy_r <= busy_r;
            endcase
        end
    end

    assign part_bus.part_array_out = work_r;
    assign part_bus.part_lo        = lo_r;
    assign part_bus.part_hi        = hi_r;
    assign part_bus.part_start     = part_start_r;
    assign sorted_out              = sorted_r;
    assign busy                    = busy_r;
    assign done                    = done_r;
    assign error                   = error_r;

endmodule

// File: tb/tb_quicksort_ctrl.sv
// Directed and randomized bench for quicksort_ctrl with a Lomuto partition
// responder and a sort/launch-count reference model.
module tb_quicksort_ctrl;
    import quicksort_ctrl_pkg::*;

    localparam int AW       = 4;
    localparam int IW       = 4;
    localparam int DW       = AW * 4;
    localparam int RESP_LAT = 5;
    localparam int BUDGET   = 2000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] array_in = '0;
    logic [DW-1:0] sorted_out;
    logic          busy, done, error;

    int checks = 0;
    int errors = 0;
    int mode = 0;        // 0 normal, 1 never ready, 2 out-of-range pivot
    int launches = 0;
    int bad_range = 0;

    quicksort_ctrl_if #(.ARR_WIDTH(AW), .IDX_W(IW)) bus ();

    quicksort_ctrl #(.ARR_WIDTH(AW), .IDX_W(IW), .STACK_DEPTH(4), .TIMEOUT(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .array_in   (array_in),
        .start      (start),
        .part_bus   (bus),
        .sorted_out (sorted_out),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lomuto(input logic [DW-1:0] a_in, input int lo, input int hi,
                                  output logic [DW-1:0] a_out);
        int e[AW];
        int pv, i, t;
        for (int k = 0; k < AW; k++) e[k] = int'(a_in[DW-1-4*k -: 4]);
        pv = e[hi];
        i  = lo;
        for (int j = lo; j < hi; j++) begin
            if (e[j] < pv) begin
                t = e[i]; e[i] = e[j]; e[j] = t; i++;
            end
        end
        t = e[i]; e[i] = e[hi]; e[hi] = t;
        a_out = '0;
        for (int k = 0; k < AW; k++) a_out[DW-1-4*k -: 4] = 4'(e[k]);
        return i;
    endfunction

    function automatic logic [DW-1:0] ref_sort(input logic [DW-1:0] a);
        int e[AW];
        int t;
        logic [DW-1:0] r;
        for (int k = 0; k < AW; k++) e[k] = int'(a[DW-1-4*k -: 4]);
        for (int x = 0; x < AW; x++)
            for (int y = 0; y < AW - 1 - x; y++)
                if (e[y] > e[y+1]) begin t = e[y]; e[y] = e[y+1]; e[y+1] = t; end
        r = '0;
        for (int k = 0; k < AW; k++) r[DW-1-4*k -: 4] = 4'(e[k]);
        return r;
    endfunction

    // Number of partitions quicksort performs: every range of 2+ elements is partitioned once.
    function automatic int model_launches(input logic [DW-1:0] arr);
        int qlo[$];
        int qhi[$];
        int n, lo, hi, p;
        logic [DW-1:0] a, a2;
        a = arr;
        n = 0;
        qlo.push_back(0);
        qhi.push_back(AW - 1);
        while (qlo.size() > 0) begin
            lo = qlo.pop_back();
            hi = qhi.pop_back();
            p  = lomuto(a, lo, hi, a2);
            a  = a2;
            n++;
            if (p + 1 < hi) begin qlo.push_back(p + 1); qhi.push_back(hi); end
            if (p - 1 > lo) begin qlo.push_back(lo); qhi.push_back(p - 1); end
        end
        return n;
    endfunction

    // Partition stage stand-in, sampled and driven on falling edges.
    initial begin
        int lo, hi, p;
        logic [DW-1:0] a, res;
        bus.part_ready    = 1'b0;
        bus.part_array_in = '0;
        bus.part_pivot    = '0;
        forever begin
            @(negedge clock);
            if (bus.part_start === 1'b1 && mode != 1) begin
                lo = int'(bus.part_lo);
                hi = int'(bus.part_hi);
                a  = bus.part_array_out;
                launches++;
                if (mode == 2) begin
                    res = a; p = 5;
                end else if (!(lo < hi && hi < AW)) begin
                    bad_range++; res = a; p = lo;
                end else begin
                    p = lomuto(a, lo, hi, res);
                end
                repeat (RESP_LAT - 1) @(negedge clock);
                bus.part_array_in = res;
                bus.part_pivot    = 4'(p);
                bus.part_ready    = 1'b1;
                @(negedge clock);
                bus.part_ready    = 1'b0;
            end
        end
    end

    task automatic wait_idle(output logic saw_done, output int cyc);
        saw_done = 1'b0;
        cyc = 0;
        while (cyc < BUDGET) begin
            if (done === 1'b1) begin saw_done = 1'b1; break; end
            if (busy !== 1'b1) break;
            @(negedge clock);
            cyc++;
        end
        check("bounded_wait", {63'd0, cyc < BUDGET}, 64'd1);
    endtask

    task automatic run_sort(input logic [DW-1:0] arr, output logic saw_done, output int cyc,
                            output int nl);
        int l0;
        l0 = launches;
        @(negedge clock);
        array_in = arr;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle(saw_done, cyc);
        nl = launches - l0;
    endtask

    task automatic do_normal(input string tag, input logic [DW-1:0] arr);
        logic sd;
        int cyc, nl;
        logic [DW-1:0] exp;
        exp = ref_sort(arr);
        run_sort(arr, sd, cyc, nl);
        check({tag, "_done"},     {63'd0, sd}, 64'd1);
        check({tag, "_sorted"},   {48'd0, sorted_out}, {48'd0, exp});
        check({tag, "_error"},    {63'd0, error}, 64'd0);
        check({tag, "_busy"},     {63'd0, busy}, 64'd0);
        check({tag, "_launches"}, 64'(nl), 64'(model_launches(arr)));
        @(negedge clock);
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_hold"},       {48'd0, sorted_out}, {48'd0, exp});
    endtask

    initial begin
        logic sd, seen;
        int cyc, nl, l0;

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        check("rst_sorted", {48'd0, sorted_out}, 64'd0);
        check("rst_pstart", {63'd0, bus.part_start}, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Directed arrays.
        do_normal("t1_3120", 16'h3120);
        do_normal("t2_sorted", 16'h0123);
        do_normal("t2_reverse", 16'h3210);

        // Duplicates, with a second start while busy that must be ignored.
        l0 = launches;
        @(negedge clock);
        array_in = 16'h2222; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        array_in = 16'h3120; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle(sd, cyc);
        check("t3_done", {63'd0, sd}, 64'd1);
        check("t3_sorted", {48'd0, sorted_out}, 64'h2222);
        check("t3_launches", 64'(launches - l0), 64'(model_launches(16'h2222)));
        repeat (3) @(negedge clock);
        check("t3_no_relaunch", {63'd0, busy}, 64'd0);

        // Randomized arrays.
        for (int k = 0; k < 8; k++) do_normal("rand", 16'($urandom));

        // Partition never answers: timeout after 64 WAIT cycles.
        mode = 1;
        run_sort(16'h3120, sd, cyc, nl);
        check("t4_no_done", {63'd0, sd}, 64'd0);
        check("t4_error", {63'd0, error}, 64'd1);
        check("t4_busy", {63'd0, busy}, 64'd0);
        check("t4_busy_cycles", 64'(cyc), 64'd67);
        check("t4_sorted_is_work", {48'd0, sorted_out}, 64'h3120);
        mode = 0;
        @(negedge clock);
        array_in = 16'h1302; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("t4_error_cleared", {63'd0, error}, 64'd0);
        wait_idle(sd, cyc);
        check("t4_recover_sorted", {48'd0, sorted_out}, 64'h0123);

        // Pivot outside the range.
        mode = 2;
        run_sort(16'h3120, sd, cyc, nl);
        check("t5_no_done", {63'd0, sd}, 64'd0);
        check("t5_error", {63'd0, error}, 64'd1);
        check("t5_launches", 64'(nl), 64'd1);
        check("t5_sorted", {48'd0, sorted_out}, 64'h3120);
        mode = 0;
        repeat (12) @(negedge clock);

        // Reset while waiting on partition.
        @(negedge clock);
        array_in = 16'h3120; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_sorted", {48'd0, sorted_out}, 64'd0);
        check("t6_error", {63'd0, error}, 64'd0);
        check("t6_pstart", {63'd0, bus.part_start}, 64'd0);
        check("t6_plo_phi", {56'd0, bus.part_lo, bus.part_hi}, 64'd0);
        check("t6_parr", {48'd0, bus.part_array_out}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        check("t6_no_done", {63'd0, seen}, 64'd0);
        do_normal("t6_1032", 16'h1032);

        check("range_valid", 64'(bad_range), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
